// File: rtl/disp_pkg.sv
// Shared constants, scan state type and the leading-zero blank helper for
// the multiplexed 7-segment display path.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_SEL_W  = 2;
    localparam int BRIGHT_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // True when digit 'sel' shows only a leading zero with no decimal point.
    // Digit 0 always stays lit so a zero value still shows "0".
    function automatic logic lz_blank(
        input logic [DIG_SEL_W-1:0]    sel,
        input logic [4*NUM_DIGITS-1:0] value,
        input logic [NUM_DIGITS-1:0]   dots
    );
        logic blank;
        blank = 1'b0;
        case (sel)
            2'd3:    blank = (value[15:12] == 4'h0) && !dots[3];
            2'd2:    blank = (value[15:8] == 8'h00) && !dots[2];
            2'd1:    blank = (value[15:4] == 12'h000) && !dots[1];
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/display_pwm_timer.sv
// Slot timer: tick counter, slot-terminal flag, per-slot brightness sample
// and the registered PWM on-window for the digit being scanned.
module display_pwm_timer
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 1000
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                advance,
    input  logic                active_next,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                slot_last,
    output logic                on_window
);

    localparam int TICK_W = $clog2(CLK_DIV);
    localparam int CMP_W  = $clog2(CLK_DIV + 1);
    localparam int STEP   = CLK_DIV / 8;

    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   tick_next;
    logic [BRIGHT_W-1:0] bright_q;
    logic [BRIGHT_W-1:0] bright_eff;
    logic [CMP_W-1:0]    on_limit;

    assign slot_last = (tick == TICK_W'(CLK_DIV - 1));

    // Next tick, the brightness in force for the slot, and its on-window length
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        tick_next = '0;
        if (advance && !slot_last) begin
            tick_next = tick + TICK_W'(1);
        end
        // At tick 0 the live input is the value being sampled for this slot.
        bright_eff = (tick == '0) ? brightness : bright_q;
        // Widen before adding one so brightness 7 gives 8 steps, not 0.
        on_limit   = (CMP_W'(bright_eff) + CMP_W'(1)) * CMP_W'(STEP);
    end

    // Tick counter, slot brightness sample and registered on-window
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            tick      <= '0;
            bright_q  <= '0;
            on_window <= 1'b0;
        end else begin
            tick <= tick_next;
            if (tick == '0) begin
                bright_q <= brightness;
            end
            on_window <= active_next && (CMP_W'(tick_next) < on_limit);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit multiplexed display scan controller: digit-select sequencing,
// frame-start strobe and a valid/ready double buffer that commits only at
// frame boundaries. Optional build macro LEADING_ZERO_BLANK_EN blanks
// leading zero digits that carry no decimal point.
module display_scan_controller
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 1000
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_value,
    input  logic [NUM_DIGITS-1:0]   wr_dots,
    output logic [DIG_SEL_W-1:0]    dig_sel,
    output logic                    digit_en,
    output logic [4*NUM_DIGITS-1:0] disp_value,
    output logic [NUM_DIGITS-1:0]   disp_dots,
    output logic                    frame_start
);

    localparam logic [DIG_SEL_W-1:0] LAST_DIGIT = DIG_SEL_W'(NUM_DIGITS - 1);

    scan_state_t                 state;
    scan_state_t                 state_next;
    logic                        slot_last;
    logic                        on_window;
    logic                        advance;
    logic                        frame_last;
    logic                        accept;
    logic                        commit;
    logic                        pending;
    logic [DIG_SEL_W-1:0]        dig_sel_next;
    logic                        frame_start_next;
    logic [4*NUM_DIGITS-1:0]     shadow_value;
    logic [NUM_DIGITS-1:0]       shadow_dots;

    assign advance    = (state == SCAN) && enable;
    assign frame_last = (state == SCAN) && slot_last && (dig_sel == LAST_DIGIT);
    assign wr_ready   = !pending;
    assign accept     = wr_valid && !pending;
    // While idle nothing is on screen to tear, so a pending shadow goes straight out.
    assign commit     = pending && ((state == IDLE) || frame_last);

    display_pwm_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_pwm_timer (
        .clock       (clock),
        .reset       (reset),
        .advance     (advance),
        .active_next (enable),
        .brightness  (brightness),
        .slot_last   (slot_last),
        .on_window   (on_window)
    );

    // Scan state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enable alone moves between idling and scanning
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = SCAN;
            SCAN:    if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next digit select and frame strobe, registered below to align with the timer
    always_comb begin
        dig_sel_next     = '0;
        frame_start_next = 1'b0;
        case (state)
            IDLE: frame_start_next = enable;
            SCAN: begin
                if (enable) begin
                    dig_sel_next     = slot_last ? dig_sel + DIG_SEL_W'(1) : dig_sel;
                    frame_start_next = frame_last;
                end
            end
            default: ;
        endcase
    end

    // Registered scan outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            dig_sel     <= dig_sel_next;
            frame_start <= frame_start_next;
        end
    end

    // Handshake flag and committed display copy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            disp_value <= '0;
            disp_dots  <= '0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit) begin
                disp_value <= shadow_value;
                disp_dots  <= shadow_dots;
            end
        end
    end

    // Shadow capture on an accepted write
    always_ff @(posedge clock) begin
        // NOTE: shadow data has no reset; it is only ever read while pending is set, after a capture.
        if (accept) begin
            shadow_value <= wr_value;
            shadow_dots  <= wr_dots;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign digit_en = on_window && !lz_blank(dig_sel, disp_value, disp_dots);
`else
    assign digit_en = on_window;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with CLK_DIV=16. A frame
// position model (cycles since scan start) predicts every output each cycle;
// directed phases cover the main scenarios, then randomized traffic follows.
module tb_display_scan_controller;

    localparam int CLK_DIV = 16;
    localparam int SLOT    = CLK_DIV;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  brightness;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_value;
    logic [3:0]  wr_dots;
    logic [1:0]  dig_sel;
    logic        digit_en;
    logic [15:0] disp_value;
    logic [3:0]  disp_dots;
    logic        frame_start;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_scan;
    int          m_pos;
    int          m_bright;
    bit          m_pending;
    bit          m_accepted;
    bit [15:0]   m_sh_val;
    bit [3:0]    m_sh_dots;
    bit [15:0]   m_disp_val;
    bit [3:0]    m_disp_dots;

    display_scan_controller #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .brightness  (brightness),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_value    (wr_value),
        .wr_dots     (wr_dots),
        .dig_sel     (dig_sel),
        .digit_en    (digit_en),
        .disp_value  (disp_value),
        .disp_dots   (disp_dots),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to the DUT.
    task automatic model_step();
        bit commit;
        m_accepted = 1'b0;
        if (reset) begin
            m_scan      = 1'b0;
            m_pos       = 0;
            m_bright    = 0;
            m_pending   = 1'b0;
            m_disp_val  = '0;
            m_disp_dots = '0;
            return;
        end
        commit = m_pending && (!m_scan || (m_pos % FRAME) == FRAME - 1);
        if (commit) begin
            m_disp_val  = m_sh_val;
            m_disp_dots = m_sh_dots;
            m_pending   = 1'b0;
        end else if (wr_valid && !m_pending) begin
            m_sh_val   = wr_value;
            m_sh_dots  = wr_dots;
            m_pending  = 1'b1;
            m_accepted = 1'b1;
        end
        if (m_scan && (m_pos % SLOT) == 0) begin
            m_bright = int'(brightness);
        end
        if (enable) begin
            if (m_scan) begin
                m_pos++;
            end else begin
                m_scan = 1'b1;
                m_pos  = 0;
            end
        end else begin
            m_scan = 1'b0;
            m_pos  = 0;
        end
    endtask

    function automatic bit model_digit_en();
        int tick;
        int digit;
        bit lit;
        tick  = m_pos % SLOT;
        digit = (m_pos / SLOT) % 4;
        lit   = m_scan && (tick < (m_bright + 1) * (CLK_DIV / 8));
`ifdef LEADING_ZERO_BLANK_EN
        if (digit != 0 && (m_disp_val >> (4 * digit)) == 16'h0 && !m_disp_dots[digit]) begin
            lit = 1'b0;
        end
`endif
        return lit;
    endfunction

    task automatic compare_all();
        check("dig_sel", 32'(dig_sel), m_scan ? 32'((m_pos / SLOT) % 4) : 32'd0);
        check("digit_en", 32'(digit_en), 32'(model_digit_en()));
        check("frame_start", 32'(frame_start), 32'(m_scan && (m_pos % FRAME) == 0));
        check("disp_value", 32'(disp_value), 32'(m_disp_val));
        check("disp_dots", 32'(disp_dots), 32'(m_disp_dots));
        check("wr_ready", 32'(wr_ready), 32'(!m_pending));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    initial begin
        int guard;
        reset      = 1'b1;
        enable     = 1'b0;
        brightness = 3'd0;
        wr_valid   = 1'b0;
        wr_value   = 16'h0;
        wr_dots    = 4'h0;

        // Reset state, then a few idle cycles.
        step_n(3);
        reset = 1'b0;
        step_n(2);

        // Full brightness scan: frame strobe at 0 and at 64.
        enable     = 1'b1;
        brightness = 3'd7;
        step();
        check("first_frame_start", 32'(frame_start), 32'd1);
        check("first_dig_sel", 32'(dig_sel), 32'd0);
        step_n(FRAME - 1);
        check("dig3_last", 32'(dig_sel), 32'd3);
        step();
        check("frame_start_64", 32'(frame_start), 32'd1);
        check("full_bright_en", 32'(digit_en), 32'd1);

        // Minimum brightness, then a mid-slot change at tick 5.
        brightness = 3'd0;
        step_n(40);
        guard = 0;
        while ((m_pos % SLOT) != 5 && guard < 100) begin
            step();
            guard++;
        end
        check("wait_tick5", 32'(guard < 100), 32'd1);
        brightness = 3'd3;
        step_n(40);

        // Write 0x1234 during digit 1; hold 0xBEEF while the shadow is busy.
        guard = 0;
        while (!(m_scan && (m_pos / SLOT) % 4 == 1) && guard < 200) begin
            step();
            guard++;
        end
        check("wait_dig1", 32'(guard < 200), 32'd1);
        wr_valid = 1'b1;
        wr_value = 16'h1234;
        wr_dots  = 4'h2;
        step();
        check("wr_ready_drop", 32'(wr_ready), 32'd0);
        wr_value = 16'hBEEF;
        wr_dots  = 4'h5;
        guard = 0;
        while (m_pending && guard < 200) begin
            step();
            guard++;
        end
        check("wait_commit1", 32'(guard < 200), 32'd1);
        check("commit_1234", 32'(disp_value), 32'h1234);
        check("commit_frame", 32'(frame_start), 32'd1);
        check("ready_after_commit", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        check("beef_held_off", 32'(disp_value), 32'h1234);
        guard = 0;
        while (m_pending && guard < 200) begin
            step();
            guard++;
        end
        check("wait_commit2", 32'(guard < 200), 32'd1);
        check("commit_beef", 32'(disp_value), 32'hBEEF);

        // Drop enable at digit 2, tick 7, then re-enable.
        guard = 0;
        while (!(m_scan && (m_pos % FRAME) == 2 * SLOT + 7) && guard < 200) begin
            step();
            guard++;
        end
        check("wait_d2t7", 32'(guard < 200), 32'd1);
        enable = 1'b0;
        step();
        check("stop_dig_sel", 32'(dig_sel), 32'd0);
        check("stop_digit_en", 32'(digit_en), 32'd0);
        step_n(3);
        enable = 1'b1;
        step();
        check("restart_frame", 32'(frame_start), 32'd1);
        step_n(5);

        // Reset in the middle of a pending write.
        wr_valid = 1'b1;
        wr_value = 16'h5555;
        wr_dots  = 4'hF;
        step();
        wr_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("reset_disp", 32'(disp_value), 32'd0);
        check("reset_ready", 32'(wr_ready), 32'd1);
        step();
        reset = 1'b0;
        step_n(2);

        // Leading-zero patterns (blanking only predicted when the macro is set).
        brightness = 3'd7;
        wr_valid   = 1'b1;
        wr_value   = 16'h0050;
        wr_dots    = 4'h0;
        step();
        wr_valid = 1'b0;
        step_n(2 * FRAME);
        wr_valid = 1'b1;
        wr_value = 16'h0000;
        wr_dots  = 4'h8;
        step();
        wr_valid = 1'b0;
        step_n(2 * FRAME);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            logic [15:0] v;
            reset  = ($urandom_range(0, 599) == 0);
            enable = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 29) == 0) begin
                brightness = 3'($urandom_range(0, 7));
            end
            wr_valid = ($urandom_range(0, 9) == 0);
            v = 16'($urandom);
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 1) == 0) begin
                    v[4*n +: 4] = 4'h0;
                end
            end
            wr_value = v;
            wr_dots  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
